// File: rtl/vga_pmod_out.sv
// vga_pmod_out: two-stage registered VGA output stage for the TinyTapeout VGA PMOD.
// Stage 1 quantises colour to 2 bits per channel (truncate, ordered dither,
// colour bars or black) and tracks pixel/line position; stage 2 registers the
// packed PMOD byte. Mode changes only take effect on a vertical sync edge.
module vga_pmod_out #(
  parameter int RG_BITS         = 3,
  parameter int B_BITS          = 2,
  parameter int H_ACTIVE        = 640,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RG_BITS-1:0] r_in,
  input  logic [RG_BITS-1:0] g_in,
  input  logic [B_BITS-1:0]  b_in,
  input  logic               de_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [1:0]         mode_req,
  output logic [7:0]         uo_out,
  output logic [1:0]         mode_cur,
  output logic [7:0]         frame_cnt
);

  localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [7:0] UO_RESET = {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};

  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'b00,
    MODE_DITHER = 2'b01,
    MODE_BARS   = 2'b10,
    MODE_BLACK  = 2'b11
  } mode_e;

  // 2x2 ordered-dither threshold matrix indexed by line and pixel parity
  function automatic logic [1:0] bayer_thr(input logic y, input logic x);
    case ({y, x})
      2'b00:   bayer_thr = 2'd0;
      2'b01:   bayer_thr = 2'd2;
      2'b10:   bayer_thr = 2'd3;
      2'b11:   bayer_thr = 2'd1;
      default: bayer_thr = 2'd0;
    endcase
  endfunction

  // Round the 2-bit value up by one when the fraction beats the threshold, saturating at 3
  function automatic logic [1:0] dither_2b(input logic [1:0] q, input logic [1:0] frac,
                                           input logic [1:0] thr);
    logic [2:0] sum;
    sum = {1'b0, q} + 3'd1;
    if (frac > thr) begin
      dither_2b = sum[2] ? 2'b11 : sum[1:0];
    end else begin
      dither_2b = q;
    end
  endfunction

  // Registered state
  logic               de_prev_q, de_prev_d;
  logic               s1_hs_q, s1_hs_d;
  logic               s1_vs_q, s1_vs_d;
  logic [1:0]         s1_r_q, s1_r_d;
  logic [1:0]         s1_g_q, s1_g_d;
  logic [1:0]         s1_b_q, s1_b_d;
  logic [7:0]         uo_q, uo_d;
  mode_e              mode_q, mode_d;
  logic [7:0]         frame_q, frame_d;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic [BCW-1:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;

  // Combinational helpers
  logic               frame_edge_s;
  logic               de_fall_s;
  logic [1:0]         thr_s;
  logic [RG_BITS+1:0] r_pad_s;
  logic [RG_BITS+1:0] g_pad_s;
  logic [B_BITS+1:0]  b_pad_s;
  logic [1:0]         r_top_s, g_top_s, b_top_s;
  logic [1:0]         r_frac_s, g_frac_s, b_frac_s;

  // Zero-pad below the LSB so the two bits under the top pair always exist
  assign r_pad_s  = {r_in, 2'b00};
  assign g_pad_s  = {g_in, 2'b00};
  assign b_pad_s  = {b_in, 2'b00};
  assign r_top_s  = r_in[RG_BITS-1 -: 2];
  assign g_top_s  = g_in[RG_BITS-1 -: 2];
  assign b_top_s  = b_in[B_BITS-1 -: 2];
  assign r_frac_s = r_pad_s[RG_BITS-1 -: 2];
  assign g_frac_s = g_pad_s[RG_BITS-1 -: 2];
  assign b_frac_s = b_pad_s[B_BITS-1 -: 2];

  // Frame edge (vsync going active) and display-enable falling edge detection
  always_comb begin
    frame_edge_s = (s1_vs_q == SYNC_IDLE) && (vs_in != SYNC_IDLE);
    de_fall_s    = de_prev_q && !de_in;
  end

  // Frame counter, frame-synchronous mode latch and position tracking
  always_comb begin
    de_prev_d = de_in;
    frame_d   = frame_edge_s ? (frame_q + 8'd1) : frame_q;
    mode_d    = frame_edge_s ? mode_e'(mode_req) : mode_q;

    if (de_in) begin
      x_d = ~x_q;
    end else if (de_fall_s) begin
      x_d = 1'b0;
    end else begin
      x_d = x_q;
    end

    if (frame_edge_s) begin
      y_d       = 1'b0;
      bar_cnt_d = '0;
      bar_idx_d = 3'd0;
    end else if (de_in) begin
      y_d = y_q;
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : (bar_idx_q + 3'd1);
      end else begin
        bar_cnt_d = bar_cnt_q + BCW'(1);
        bar_idx_d = bar_idx_q;
      end
    end else if (de_fall_s) begin
      y_d       = ~y_q;
      bar_cnt_d = '0;
      bar_idx_d = 3'd0;
    end else begin
      y_d       = y_q;
      bar_cnt_d = bar_cnt_q;
      bar_idx_d = bar_idx_q;
    end
  end

  // Stage 1: colour reduction for the current pixel using the mode in effect
  always_comb begin
    thr_s   = bayer_thr(y_q, x_q ^ frame_q[0]);
    s1_hs_d = hs_in;
    s1_vs_d = vs_in;
    s1_r_d  = 2'b00;
    s1_g_d  = 2'b00;
    s1_b_d  = 2'b00;
    if (de_in) begin
      case (mode_q)
        MODE_TRUNC: begin
          s1_r_d = r_top_s;
          s1_g_d = g_top_s;
          s1_b_d = b_top_s;
        end
        MODE_DITHER: begin
          s1_r_d = dither_2b(r_top_s, r_frac_s, thr_s);
          s1_g_d = dither_2b(g_top_s, g_frac_s, thr_s);
          s1_b_d = dither_2b(b_top_s, b_frac_s, thr_s);
        end
        MODE_BARS: begin
          s1_r_d = {2{bar_idx_q[2]}};
          s1_g_d = {2{bar_idx_q[1]}};
          s1_b_d = {2{bar_idx_q[0]}};
        end
        MODE_BLACK: begin
          s1_r_d = 2'b00;
          s1_g_d = 2'b00;
          s1_b_d = 2'b00;
        end
        default: begin
          s1_r_d = 2'b00;
          s1_g_d = 2'b00;
          s1_b_d = 2'b00;
        end
      endcase
    end else begin
      s1_r_d = 2'b00;
      s1_g_d = 2'b00;
      s1_b_d = 2'b00;
    end
  end

  // Stage 2: pack stage-1 colour and syncs into the PMOD pin order
  always_comb begin
    uo_d = {s1_hs_q, s1_b_q[0], s1_g_q[0], s1_r_q[0],
            s1_vs_q, s1_b_q[1], s1_g_q[1], s1_r_q[1]};
  end

  // All state registers with synchronous reset to blank output and idle syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      de_prev_q <= 1'b0;
      s1_hs_q   <= SYNC_IDLE;
      s1_vs_q   <= SYNC_IDLE;
      s1_r_q    <= 2'b00;
      s1_g_q    <= 2'b00;
      s1_b_q    <= 2'b00;
      uo_q      <= UO_RESET;
      mode_q    <= MODE_TRUNC;
      frame_q   <= 8'd0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      bar_cnt_q <= '0;
      bar_idx_q <= 3'd0;
    end else begin
      de_prev_q <= de_prev_d;
      s1_hs_q   <= s1_hs_d;
      s1_vs_q   <= s1_vs_d;
      s1_r_q    <= s1_r_d;
      s1_g_q    <= s1_g_d;
      s1_b_q    <= s1_b_d;
      uo_q      <= uo_d;
      mode_q    <= mode_d;
      frame_q   <= frame_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  assign uo_out    = uo_q;
  assign mode_cur  = mode_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_pmod_out.sv
// tb_vga_pmod_out: table-driven and sequence tests for vga_pmod_out with a
// two-deep expected-output queue matching the output latency.
module tb_vga_pmod_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] r_in = 3'd0;
  logic [2:0] g_in = 3'd0;
  logic [1:0] b_in = 2'd0;
  logic       de_in = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic [7:0] uo_out;
  logic [1:0] mode_cur;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  vga_pmod_out #(
    .RG_BITS(3), .B_BITS(2), .H_ACTIVE(640), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .mode_req(mode_req),
    .uo_out(uo_out), .mode_cur(mode_cur), .frame_cnt(frame_cnt)
  );

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  int         total_cnt = 0;
  int         exp_frame = 0;

  typedef struct {
    logic [1:0] md;
    logic       de;
    logic       hs;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic hs, input logic vs,
                                      input logic [1:0] r, input logic [1:0] g,
                                      input logic [1:0] b);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // One cycle: compare the output due now, then drive new inputs and queue their expectation
  task automatic drive(input logic rs, input logic [1:0] md, input logic [2:0] r,
                       input logic [2:0] g, input logic [1:0] b, input logic de,
                       input logic hs, input logic vs, input logic chk,
                       input logic [7:0] exp, input string nm);
    logic [8:0] e;
    string      n;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e[8]) check8(n, uo_out, e[7:0]);
    end
    rst = rs; mode_req = md; r_in = r; g_in = g; b_in = b;
    de_in = de; hs_in = hs; vs_in = vs;
    if (rs) begin
      exp_q.delete();
      name_q.delete();
      exp_q.push_back({1'b1, 8'h88}); name_q.push_back("reset_out");
      exp_q.push_back({1'b1, 8'h88}); name_q.push_back("reset_out_next");
    end else begin
      exp_q.push_back({chk, exp}); name_q.push_back(nm);
    end
  endtask

  task automatic px(input logic [1:0] md, input logic [2:0] r, input logic [2:0] g,
                    input logic [1:0] b, input logic de, input logic [7:0] exp,
                    input string nm);
    drive(1'b0, md, r, g, b, de, 1'b1, 1'b1, 1'b1, exp, nm);
  endtask

  task automatic blank(input logic [1:0] md, input int n);
    for (int k = 0; k < n; k++) px(md, 3'd7, 3'd7, 2'd3, 1'b0, 8'h88, "blank");
  endtask

  // Vertical sync pulse (two cycles active) followed by a check of frame count and mode
  task automatic vs_pulse(input logic [1:0] md);
    drive(1'b0, md, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, "vsync_out");
    drive(1'b0, md, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, "vsync_out");
    drive(1'b0, md, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h88, "vsync_end");
    exp_frame = (exp_frame + 1) % 256;
    check8("frame_cnt", frame_cnt, 8'(exp_frame));
    check8("mode_cur", {6'd0, mode_cur}, {6'd0, md});
  endtask

  function automatic logic [7:0] bar_exp(input int p);
    int         i;
    logic [2:0] bi;
    i  = (p / 80 > 7) ? 7 : p / 80;
    bi = 3'(i);
    return pack(1'b1, 1'b1, {2{bi[2]}}, {2{bi[1]}}, {2{bi[0]}});
  endfunction

  initial begin
    vecs[0] = '{2'b00, 1'b1, 1'b1, 3'd5, 3'd3, 2'd2, 8'hAD};
    vecs[1] = '{2'b00, 1'b0, 1'b1, 3'd5, 3'd3, 2'd2, 8'h88};
    vecs[2] = '{2'b11, 1'b1, 1'b1, 3'd7, 3'd7, 2'd3, 8'hFF};
    vecs[3] = '{2'b01, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 8'h08};
    vecs[4] = '{2'b10, 1'b1, 1'b1, 3'd2, 3'd4, 2'd1, 8'hDA};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 3'd7, 3'd7, 2'd3, 8'h08};

    // Reset with arbitrary inputs
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, "");
      if (k == 1) begin
        check8("reset_mode_cur", {6'd0, mode_cur}, 8'd0);
        check8("reset_frame_cnt", frame_cnt, 8'd0);
      end
    end
    exp_frame = 0;

    // Truncation table; mode_req changes here must not take effect mid-frame
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, vecs[k].md, vecs[k].r, vecs[k].g, vecs[k].b, vecs[k].de,
            vecs[k].hs, 1'b1, 1'b1, vecs[k].exp, $sformatf("table_%0d", k));
    end
    blank(2'b00, 2);

    // Frame-synchronous mode change 00 -> 11
    for (int k = 0; k < 4; k++) px(2'b00, 3'd5, 3'd3, 2'd2, 1'b1, 8'hAD, "trunc_line");
    for (int k = 0; k < 4; k++) px(2'b11, 3'd5, 3'd3, 2'd2, 1'b1, 8'hAD, "midline_req");
    blank(2'b11, 2);
    vs_pulse(2'b11);
    for (int k = 0; k < 3; k++) px(2'b11, 3'd5, 3'd3, 2'd2, 1'b1, 8'h88, "black_mode");
    blank(2'b11, 2);

    // Dither, even frame
    vs_pulse(2'b01);
    blank(2'b01, 1);
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h89, "dith_y0x0");
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h98, "dith_y0x1");
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h89, "dith_y0x2");
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h98, "dith_y0x3");
    px(2'b01, 3'b111, 3'b101, 2'b01, 1'b1, 8'hFB, "dith_sat");
    blank(2'b01, 1);
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h98, "dith_y1x0");
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h89, "dith_y1x1");
    blank(2'b01, 2);

    // Dither, odd frame: pattern swaps
    vs_pulse(2'b01);
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h98, "dith_f1_y0x0");
    px(2'b01, 3'b011, 3'd0, 2'd0, 1'b1, 8'h89, "dith_f1_y0x1");
    blank(2'b01, 2);

    // Colour bars over a line longer than H_ACTIVE
    vs_pulse(2'b10);
    for (int p = 0; p <= 700; p++) begin
      px(2'b10, 3'($urandom), 3'($urandom), 2'($urandom), 1'b1, bar_exp(p),
         $sformatf("bars_px%0d", p));
    end
    blank(2'b10, 2);

    // Reset in the middle of a bar line
    vs_pulse(2'b10);
    for (int p = 0; p < 150; p++) begin
      px(2'b10, 3'd0, 3'd0, 2'd0, 1'b1, bar_exp(p), $sformatf("bars2_px%0d", p));
    end
    drive(1'b1, 2'b10, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "");
    px(2'b00, 3'd7, 3'd7, 2'd3, 1'b1, 8'hFF, "post_reset_px");
    check8("midline_reset_mode_cur", {6'd0, mode_cur}, 8'd0);
    check8("midline_reset_frame_cnt", frame_cnt, 8'd0);
    exp_frame = 0;
    px(2'b00, 3'd5, 3'd3, 2'd2, 1'b1, 8'hAD, "post_reset_trunc");
    blank(2'b00, 2);
    vs_pulse(2'b10);
    for (int p = 0; p < 100; p++) begin
      px(2'b10, 3'd7, 3'd7, 2'd3, 1'b1, bar_exp(p), $sformatf("bars3_px%0d", p));
    end
    blank(2'b10, 2);

    // Frame counter wrap 255 -> 0
    while (exp_frame != 0 || total_cnt == 0) begin
      vs_pulse(2'b00);
    end

    blank(2'b00, 3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
